// File: rtl/cv32e40px_hwloop_pkg.sv
// Shared constants and types for the hardware-loop register bank.
package cv32e40px_hwloop_pkg;

    // Bit positions inside hwlp_we_i
    localparam int HWLP_WE_START = 0;
    localparam int HWLP_WE_END   = 1;
    localparam int HWLP_WE_CNT   = 2;

    // Largest supported number of hardware loops
    localparam int HWLP_MAX_REGS = 8;

    // One loop's architectural state at the default 32-bit widths, for users
    // that want to carry a whole loop around as a single value.
    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
        logic [31:0] cnt;
    } hwlp_regs_t;

endpackage

// File: rtl/cv32e40px_hwloop_cnt.sv
// Single hardware-loop counter: priority write > decrement > saturate at zero.
// Produces a registered done pulse on the 1->0 step and a combinational flag
// for a decrement request that hit an already-zero counter.
module cv32e40px_hwloop_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             done,
    output logic             zero_dec
);

    logic is_zero;
    logic is_one;

    assign is_zero  = (cnt == '0);
    assign is_one   = (cnt == CNT_W'(1));
    // A write in the same cycle wins, so it also masks the zero-decrement case
    assign zero_dec = dec && !we && is_zero;

    // Counter register: write has priority, decrement never wraps below zero
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (we)
            cnt <= wdata;
        else if (dec && !is_zero)
            cnt <= cnt - CNT_W'(1);
    end

    // Done pulse: one cycle after a real 1->0 decrement, never on a write cycle
    always_ff @(posedge clk) begin
        if (rst)
            done <= 1'b0;
        else
            done <= dec && !we && is_one;
    end

endmodule

// File: rtl/cv32e40px_hwloop_bank.sv
// Parametrised hardware-loop register bank (start, end, counter per loop).
// Optional sticky error detection is built when CV32E40PX_HWLP_ERR_CHECK_EN
// is defined; otherwise hwlp_err_o is tied low.
module cv32e40px_hwloop_bank
    import cv32e40px_hwloop_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              hwlp_start_data_i,
    input  logic [ADDR_W-1:0]              hwlp_end_data_i,
    input  logic [CNT_W-1:0]               hwlp_cnt_data_i,
    input  logic [2:0]                     hwlp_we_i,
    input  logic [N_REG_BITS-1:0]          hwlp_regid_i,
    input  logic                           valid_i,
    input  logic [N_REGS-1:0]              hwlp_dec_cnt_i,
    output logic [N_REGS-1:0][ADDR_W-1:0]  hwlp_start_addr_o,
    output logic [N_REGS-1:0][ADDR_W-1:0]  hwlp_end_addr_o,
    output logic [N_REGS-1:0][CNT_W-1:0]   hwlp_counter_o,
    output logic [N_REGS-1:0]              hwlp_active_o,
    output logic [N_REGS-1:0]              hwlp_done_o,
    output logic                           hwlp_err_o
);

    logic              regid_ok;
    logic [N_REGS-1:0] sel;
    logic [N_REGS-1:0] dec_q;
    logic [N_REGS-1:0] zero_dec;

    // Indices past N_REGS exist only when N_REGS is not a power of two
    assign regid_ok = int'(hwlp_regid_i) < N_REGS;
    assign dec_q    = valid_i ? hwlp_dec_cnt_i : '0;

    for (genvar k = 0; k < N_REGS; k++) begin : g_loop
        assign sel[k]           = regid_ok && (hwlp_regid_i == N_REG_BITS'(k));
        assign hwlp_active_o[k] = |hwlp_counter_o[k];

        cv32e40px_hwloop_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .we       (sel[k] && hwlp_we_i[HWLP_WE_CNT]),
            .wdata    (hwlp_cnt_data_i),
            .dec      (dec_q[k]),
            .cnt      (hwlp_counter_o[k]),
            .done     (hwlp_done_o[k]),
            .zero_dec (zero_dec[k])
        );
    end

    // Start/end address registers; loop bodies are word aligned so bits [1:0] drop
    always_ff @(posedge clk) begin
        if (rst) begin
            hwlp_start_addr_o <= '0;
            hwlp_end_addr_o   <= '0;
        end else begin
            for (int k = 0; k < N_REGS; k++) begin
                if (sel[k] && hwlp_we_i[HWLP_WE_START])
                    hwlp_start_addr_o[k] <= {hwlp_start_data_i[ADDR_W-1:2], 2'b00};
                if (sel[k] && hwlp_we_i[HWLP_WE_END])
                    hwlp_end_addr_o[k]   <= {hwlp_end_data_i[ADDR_W-1:2], 2'b00};
            end
        end
    end

`ifdef CV32E40PX_HWLP_ERR_CHECK_EN
    logic multi_dec;
    logic bad_regid;

    // More than one bit set: clearing the lowest set bit leaves something behind
    assign multi_dec = (dec_q & (dec_q - N_REGS'(1))) != '0;
    assign bad_regid = (|hwlp_we_i) && !regid_ok;

    // Sticky error flag, only reset clears it
    always_ff @(posedge clk) begin
        if (rst)
            hwlp_err_o <= 1'b0;
        else if (multi_dec || (|zero_dec) || bad_regid)
            hwlp_err_o <= 1'b1;
    end
`else
    logic [N_REGS-1:0] unused_zero_dec;

    assign unused_zero_dec = zero_dec;
    assign hwlp_err_o      = 1'b0;
`endif

endmodule

// File: doc/cv32e40px_hwloop_bank.md
Name: cv32e40px_hwloop_bank

Overview:
- Parametrised hardware-loop register bank: stores start address, end address and iteration counter for N_REGS loops.
- Generalises the fixed 2-loop, 32-bit bank with:
  - configurable loop count, address width and counter width;
  - a saturating counter that does not wrap below zero;
  - per-loop active flags and loop-done pulses;
  - optional error detection.
- Sits between the EX stage (setup writes), the controller (valid_i) and the hwloop controller (decrement requests, address/counter consumers).

Parameters:
- N_REGS, 2, number of hardware loops; legal range 1..8.
- N_REG_BITS, max(1,$clog2(N_REGS)), width of the loop-select index.
- ADDR_W, 32, width of stored start/end addresses; must be at least 3.
- CNT_W, 32, width of loop counters.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- hwlp_start_data_i  in  ADDR_W  start-address write data.
- hwlp_end_data_i  in  ADDR_W  end-address write data.
- hwlp_cnt_data_i  in  CNT_W  counter write data.
- hwlp_we_i  in  3  write enables: [0] start, [1] end, [2] counter.
- hwlp_regid_i  in  N_REG_BITS  selects which loop is written.
- valid_i  in  1  instruction-valid qualifier for decrements.
- hwlp_dec_cnt_i  in  N_REGS  per-loop decrement request.
- hwlp_start_addr_o  out  N_REGS x ADDR_W  stored start addresses.
- hwlp_end_addr_o  out  N_REGS x ADDR_W  stored end addresses.
- hwlp_counter_o  out  N_REGS x CNT_W  stored counters.
- hwlp_active_o  out  N_REGS  loop k has a nonzero counter.
- hwlp_done_o  out  N_REGS  one-cycle pulse: loop k's counter was decremented from 1 to 0.
- hwlp_err_o  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset:
  - Synchronous: sampled at the rising clk edge with rst=1.
  - Clears all start/end/counter registers, done pulses and the error flag.
  - After reset all outputs read 0.
  - Reset asserted mid-loop overrides any write or decrement in that cycle.
- Address writes:
  - we[0] or we[1] writes the selected start or end register, with bits [1:0] forced to 0.
  - Visible on the outputs one cycle later.
  - we[0] and we[1] may be asserted in the same cycle.
- Out-of-range regid: if hwlp_regid_i >= N_REGS (possible when N_REGS is not a power of two), writes are ignored; no state changes.
- Counter update, per loop k, in priority order:
  - (1) we[2] && regid==k: counter <= cnt_data.
  - (2) else if valid_i && dec[k] && counter!=0: counter <= counter-1 (modulo CNT_W).
  - (3) else if valid_i && dec[k] && counter==0: counter holds at 0 (saturate, no wrap).
  - (4) else: hold.
- Decrements require valid_i=1; dec[k] with valid_i=0 has no effect.
- hwlp_active_o[k] is the OR-reduction of counter_q[k]. It is combinational from the register, so it has no extra latency.
- hwlp_done_o[k]:
  - Registered; high for exactly one cycle, in the cycle after rule (2) took counter_q[k] from 1 to 0.
  - A same-cycle write to loop k suppresses the pulse.
- Simultaneous decrements to several loops in one valid cycle are all applied independently.
- Write and decrement on different loops in the same cycle: both take effect.

Optional Feature:
- Macro: CV32E40PX_HWLP_ERR_CHECK_EN.
- Defined:
  - hwlp_err_o is a sticky register, cleared only by rst.
  - It sets on a valid_i cycle with more than one dec bit high.
  - It also sets on a valid_i decrement request to a loop whose counter is 0 (rule 3).
  - It also sets on an out-of-range regid write.
  - Sets one cycle after the offending event.
- Not defined: hwlp_err_o is tied to 0 and no error-detection logic is built.

Decomposition:
- Package cv32e40px_hwloop_pkg holds:
  - the HWLP_WE_START/END/CNT bit-index constants;
  - the maximum N_REGS constant (8);
  - the per-loop struct type (start, end, cnt) for nested use.
- One sub-module, cv32e40px_hwloop_cnt, implements a single loop's counter: priority write/decrement/saturate, done pulse and zero-decrement flag. It is instantiated N_REGS times via a generate loop.
- Start/end registers and error aggregation stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with writes active → all counters, addresses, active, done and err read 0.
- Setup and count down:
  - Write loop 1: start=0x1003, end=0x1043, cnt=3 in one cycle → start reads 0x1000, end 0x1040, active[1]=1.
  - Apply 3 valid decrements → counter steps 2, 1, 0.
  - done[1] pulses for exactly the cycle after the 1→0 transition, then active[1]=0.
- Saturation: counter=0, valid_i=1, dec[0]=1 → counter stays 0 and no done pulse; with the macro defined, err=1 the next cycle.
- Collision: loop 0 counter=1; same cycle we[2]=1, regid=0, cnt=5, dec[0]=1, valid_i=1 → counter=5, no done pulse.
- Parametrisation:
  - N_REGS=3, CNT_W=8: write regid=3 → no state change (err=1 when the macro is defined).
  - counter=0x01 on loop 2 decrements to 0x00 with a done pulse.
- Multi-decrement: valid_i=1, dec=2'b11, counters 4 and 7 → they become 3 and 6; err=1 only when the macro is defined; valid_i=0 leaves both unchanged.
